// File: rtl/dut_prod_accum_pkg.sv
// rtl/dut_prod_accum_pkg.sv - shared state enum and default widths for the product accumulator
package dut_prod_accum_pkg;

  localparam int DIN_WIDTH_D = 28;
  localparam int LEN_WIDTH_D = 10;
  localparam int ACC_WIDTH_D = DIN_WIDTH_D + LEN_WIDTH_D;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;

endpackage

// File: rtl/dut_prod_accum_if.sv
// rtl/dut_prod_accum_if.sv - job control, product input and result output bundle
interface dut_prod_accum_if
  import dut_prod_accum_pkg::*;
#(
  parameter int DIN_WIDTH = DIN_WIDTH_D,
  parameter int LEN_WIDTH = LEN_WIDTH_D,
  parameter int ACC_WIDTH = ACC_WIDTH_D
);
  logic                 start;
  logic [LEN_WIDTH-1:0] len;
  logic                 busy;
  logic                 in_valid;
  logic [DIN_WIDTH-1:0] in_data;
  logic                 in_ready;
  logic                 out_valid;
  logic [ACC_WIDTH-1:0] out_data;
  logic                 out_ready;
  logic                 ovf;

  modport master (
    output start, len, in_valid, in_data, out_ready,
    input  busy, in_ready, out_valid, out_data, ovf
  );

  modport slave (
    input  start, len, in_valid, in_data, out_ready,
    output busy, in_ready, out_valid, out_data, ovf
  );
endinterface

// File: rtl/dut_prod_accum_add.sv
// rtl/dut_prod_accum_add.sv - accumulator adder; DUT_PROD_ACCUM_SAT_EN adds carry detect and clamp
module dut_prod_accum_add
  import dut_prod_accum_pkg::*;
#(
  parameter int DIN_WIDTH = DIN_WIDTH_D,
  parameter int ACC_WIDTH = ACC_WIDTH_D
) (
  input  logic [ACC_WIDTH-1:0] i_acc,
  input  logic [DIN_WIDTH-1:0] i_din,
  output logic [ACC_WIDTH-1:0] o_sum,
  output logic                 o_ovf
);
`ifdef DUT_PROD_ACCUM_SAT_EN
  logic [ACC_WIDTH:0] w_full;

  assign w_full = {1'b0, i_acc} + (ACC_WIDTH + 1)'(i_din);
  assign o_ovf  = w_full[ACC_WIDTH];
  // Once clamped to all-ones any non-zero add carries again, so saturation holds for the job
  assign o_sum  = o_ovf ? {ACC_WIDTH{1'b1}} : w_full[ACC_WIDTH-1:0];
`else
  assign o_sum = i_acc + ACC_WIDTH'(i_din);
  assign o_ovf = 1'b0;
`endif
endmodule

// File: rtl/dut_prod_accum.sv
// rtl/dut_prod_accum.sv - sums a programmed number of products; saturation via DUT_PROD_ACCUM_SAT_EN in the adder
module dut_prod_accum
  import dut_prod_accum_pkg::*;
#(
  parameter int DIN_WIDTH = DIN_WIDTH_D,
  parameter int LEN_WIDTH = LEN_WIDTH_D,
  parameter int ACC_WIDTH = ACC_WIDTH_D
) (
  input  logic            ap_clk,
  input  logic            ap_rst_n,
  dut_prod_accum_if.slave bus
);
  state_t               r_state;
  state_t               w_state_nxt;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [LEN_WIDTH-1:0] r_cnt;
  logic                 r_ovf;
  logic [ACC_WIDTH-1:0] w_sum;
  logic                 w_add_ovf;
  logic                 w_start_ok;
  logic                 w_beat;
  logic                 w_busy;
  logic                 w_in_ready;
  logic                 w_out_valid;

  dut_prod_accum_add #(
    .DIN_WIDTH (DIN_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_add (
    .i_acc (r_acc),
    .i_din (bus.in_data),
    .o_sum (w_sum),
    .o_ovf (w_add_ovf)
  );

  assign w_start_ok = (r_state == IDLE) && bus.start;
  assign w_beat     = w_in_ready && bus.in_valid;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b1;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (bus.start) begin
          w_state_nxt = (bus.len == '0) ? OUT : ACC;
        end
      end
      ACC: begin
        w_in_ready = 1'b1;
        if (bus.in_valid && (r_cnt == LEN_WIDTH'(1))) begin
          w_state_nxt = OUT;
        end
      end
      OUT: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // The accumulator doubles as the result register, so out_data is stable throughout OUT
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_start_ok) begin
      r_acc <= '0;
      r_cnt <= bus.len;
      r_ovf <= 1'b0;
    end else if (w_beat) begin
      r_acc <= w_sum;
      r_cnt <= r_cnt - LEN_WIDTH'(1);
      r_ovf <= r_ovf | w_add_ovf;
    end
  end

  assign bus.busy      = w_busy;
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = r_acc;
  assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_dut_prod_accum.sv
// tb/tb_dut_prod_accum.sv - directed bench for dut_prod_accum; DUT_PROD_ACCUM_SAT_EN selects the 29-bit saturating build
module tb_dut_prod_accum;
  localparam int DINW = 28;
  localparam int LENW = 10;
`ifdef DUT_PROD_ACCUM_SAT_EN
  localparam int ACCW = 29;
`else
  localparam int ACCW = 38;
`endif
  localparam logic [DINW-1:0] PMAX = 28'hFFF_FFFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  dut_prod_accum_if #(.DIN_WIDTH(DINW), .LEN_WIDTH(LENW), .ACC_WIDTH(ACCW)) bus ();

  dut_prod_accum #(.DIN_WIDTH(DINW), .LEN_WIDTH(LENW), .ACC_WIDTH(ACCW)) u_dut (
    .ap_clk   (clk),
    .ap_rst_n (rst_n),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [ACCW-1:0] exp_sum(input longint s);
    longint lim;
    lim = (longint'(1) << ACCW) - 1;
`ifdef DUT_PROD_ACCUM_SAT_EN
    return (s > lim) ? ACCW'(lim) : ACCW'(s);
`else
    return ACCW'(s & lim);
`endif
  endfunction

  function automatic logic exp_ovf(input longint s);
`ifdef DUT_PROD_ACCUM_SAT_EN
    return s > ((longint'(1) << ACCW) - 1);
`else
    return (s < 0);
`endif
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    bus.start = 0; bus.len = '0; bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 0;
    rst_n = 0;
    tick; tick;
    n_tests++;
    if ({bus.busy, bus.in_ready, bus.out_valid, bus.ovf} !== 4'b0 || bus.out_data !== '0) begin
      $display("FAIL reset_outputs got busy=%b rdy=%b ov=%b ovf=%b data=%0d exp all 0",
               bus.busy, bus.in_ready, bus.out_valid, bus.ovf, bus.out_data);
      n_fail++;
    end
    rst_n = 1;
    tick;
    n_tests++;
    if (bus.busy !== 1'b0) begin
      $display("FAIL idle_after_reset got busy=%b exp 0", bus.busy); n_fail++;
    end
  endtask

  task automatic test_basic;
    bus.out_ready = 1; bus.start = 1; bus.len = 3;
    tick;
    bus.start = 0;
    n_tests++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b1) begin
      $display("FAIL basic_acc_entry got busy=%b rdy=%b exp 1 1", bus.busy, bus.in_ready); n_fail++;
    end
    bus.in_valid = 1; bus.in_data = 100; tick;
    bus.in_data = 200; tick;
    bus.in_data = 300; tick;
    bus.in_valid = 0;
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== ACCW'(600) || bus.in_ready !== 1'b0) begin
      $display("FAIL basic_result got ov=%b data=%0d rdy=%b exp 1 600 0",
               bus.out_valid, bus.out_data, bus.in_ready); n_fail++;
    end
    tick;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      $display("FAIL basic_busy_fall got busy=%b ov=%b exp 0 0", bus.busy, bus.out_valid); n_fail++;
    end
  endtask

  task automatic test_gaps;
    int v[7] = '{1, 0, 0, 1, 1, 0, 1};
    int gap_err = 0;
    bus.out_ready = 1; bus.start = 1; bus.len = 4;
    tick;
    bus.start = 0;
    for (int i = 0; i < 7; i++) begin
      bus.in_valid = v[i][0];
      bus.in_data  = PMAX;
      if (bus.in_ready !== 1'b1) gap_err++;
      tick;
    end
    bus.in_valid = 0;
    n_tests++;
    if (gap_err != 0) begin
      $display("FAIL gaps_in_ready got %0d low cycles exp 0", gap_err); n_fail++;
    end
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== exp_sum(64'd1073741820) ||
        bus.ovf !== exp_ovf(64'd1073741820)) begin
      $display("FAIL gaps_result got ov=%b data=%0d ovf=%b exp 1 %0d %b", bus.out_valid,
               bus.out_data, bus.ovf, exp_sum(64'd1073741820), exp_ovf(64'd1073741820)); n_fail++;
    end
    tick;
  endtask

  task automatic test_backpressure;
    int bp_err = 0;
    bus.out_ready = 0; bus.start = 1; bus.len = 1;
    tick;
    bus.start = 0; bus.in_valid = 1; bus.in_data = 42;
    tick;
    bus.in_data = 99;
    for (int i = 0; i < 5; i++) begin
      if (bus.out_valid !== 1'b1 || bus.out_data !== ACCW'(42) || bus.in_ready !== 1'b0) bp_err++;
      bus.start = (i == 2);
      bus.len = 5;
      tick;
    end
    bus.start = 0;
    n_tests++;
    if (bp_err != 0 || bus.out_valid !== 1'b1 || bus.out_data !== ACCW'(42)) begin
      $display("FAIL bp_hold got %0d bad cycles, ov=%b data=%0d exp 0 1 42",
               bp_err, bus.out_valid, bus.out_data); n_fail++;
    end
    bus.out_ready = 1;
    tick;
    bus.in_valid = 0;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      $display("FAIL bp_release got busy=%b ov=%b exp 0 0", bus.busy, bus.out_valid); n_fail++;
    end
  endtask

  task automatic test_len0;
    bus.out_ready = 0; bus.in_valid = 1; bus.in_data = 77;
    bus.start = 1; bus.len = 0;
    tick;
    bus.start = 0;
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== '0 || bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
      $display("FAIL len0_result got ov=%b data=%0d rdy=%b busy=%b exp 1 0 0 1",
               bus.out_valid, bus.out_data, bus.in_ready, bus.busy); n_fail++;
    end
    bus.out_ready = 1;
    tick;
    bus.in_valid = 0;
    n_tests++;
    if (bus.busy !== 1'b0) begin
      $display("FAIL len0_done got busy=%b exp 0", bus.busy); n_fail++;
    end
  endtask

  task automatic test_reset_mid;
    bus.out_ready = 1; bus.start = 1; bus.len = 5;
    tick;
    bus.start = 0; bus.in_valid = 1; bus.in_data = 1000; tick;
    bus.in_data = 2000; tick;
    #2 rst_n = 0;
    #1;
    n_tests++;
    if ({bus.busy, bus.in_ready, bus.out_valid, bus.ovf} !== 4'b0 || bus.out_data !== '0) begin
      $display("FAIL midreset_outputs got busy=%b rdy=%b ov=%b ovf=%b data=%0d exp all 0",
               bus.busy, bus.in_ready, bus.out_valid, bus.ovf, bus.out_data); n_fail++;
    end
    bus.in_valid = 0;
    tick;
    rst_n = 1;
    tick;
    bus.start = 1; bus.len = 2; tick;
    bus.start = 0; bus.in_valid = 1; bus.in_data = 7; tick;
    bus.in_data = 8; tick;
    bus.in_valid = 0;
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== ACCW'(15)) begin
      $display("FAIL midreset_newjob got ov=%b data=%0d exp 1 15", bus.out_valid, bus.out_data); n_fail++;
    end
    tick;
  endtask

  task automatic test_back_to_back;
    bus.out_ready = 1; bus.start = 1; bus.len = 1; tick;
    bus.start = 0; bus.in_valid = 1; bus.in_data = 5; tick;
    bus.in_valid = 0;
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== ACCW'(5) || bus.ovf !== 1'b0) begin
      $display("FAIL b2b_first got ov=%b data=%0d ovf=%b exp 1 5 0", bus.out_valid, bus.out_data, bus.ovf); n_fail++;
    end
    bus.start = 1; bus.len = 2;
    tick;
    n_tests++;
    if (bus.busy !== 1'b0) begin
      $display("FAIL b2b_start_in_out got busy=%b exp 0", bus.busy); n_fail++;
    end
    tick;
    bus.start = 0;
    n_tests++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b1) begin
      $display("FAIL b2b_restart got busy=%b rdy=%b exp 1 1", bus.busy, bus.in_ready); n_fail++;
    end
    bus.in_valid = 1; bus.in_data = 9; tick;
    bus.in_data = 11; tick;
    bus.in_valid = 0;
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== ACCW'(20)) begin
      $display("FAIL b2b_second got ov=%b data=%0d exp 1 20", bus.out_valid, bus.out_data); n_fail++;
    end
    tick;
  endtask

  task automatic test_len_max;
    bus.out_ready = 1; bus.start = 1; bus.len = 10'h3FF; tick;
    bus.start = 0; bus.in_valid = 1; bus.in_data = PMAX;
    repeat (1022) tick;
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      $display("FAIL lenmax_early got ov=%b rdy=%b exp 0 1", bus.out_valid, bus.in_ready); n_fail++;
    end
    tick;
    bus.in_valid = 0;
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== exp_sum(64'd274609470465) ||
        bus.ovf !== exp_ovf(64'd274609470465)) begin
      $display("FAIL lenmax_result got ov=%b data=%0d ovf=%b exp 1 %0d %b", bus.out_valid,
               bus.out_data, bus.ovf, exp_sum(64'd274609470465), exp_ovf(64'd274609470465)); n_fail++;
    end
    tick;
  endtask

`ifdef DUT_PROD_ACCUM_SAT_EN
  task automatic test_sat;
    bus.out_ready = 1; bus.start = 1; bus.len = 3; tick;
    bus.start = 0; bus.in_valid = 1; bus.in_data = PMAX;
    repeat (3) tick;
    bus.in_valid = 0;
    n_tests++;
    if (bus.out_data !== 29'h1FFF_FFFF || bus.ovf !== 1'b1) begin
      $display("FAIL sat_clamp got data=%0d ovf=%b exp %0d 1", bus.out_data, bus.ovf, 29'h1FFF_FFFF); n_fail++;
    end
    tick;
    bus.start = 1; bus.len = 1; tick;
    bus.start = 0; bus.in_valid = 1; bus.in_data = 5; tick;
    bus.in_valid = 0;
    n_tests++;
    if (bus.out_data !== ACCW'(5) || bus.ovf !== 1'b0) begin
      $display("FAIL sat_clear got data=%0d ovf=%b exp 5 0", bus.out_data, bus.ovf); n_fail++;
    end
    tick;
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_gaps;
    test_backpressure;
    test_len0;
    test_reset_mid;
    test_back_to_back;
    test_len_max;
`ifdef DUT_PROD_ACCUM_SAT_EN
    test_sat;
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dut_prod_accum.md
Name: dut_prod_accum

Overview:
- Downstream consumer of the 13x15 unsigned multiplier's 28-bit product stream.
- Accumulates a programmed number of products into a wide unsigned sum, e.g. a dot-product / filter tap reduction.
- Sequential: valid/ready input handshake, length counter, 3-state FSM, registered output held until accepted.
- Sits between the combinational multiplier and the result write-back logic of the dut top.

Parameters:
- DIN_WIDTH, 28, width of each incoming product.
- LEN_WIDTH, 10, width of the term-count field; max terms = 2^LEN_WIDTH-1.
- ACC_WIDTH, 38, accumulator width; default = DIN_WIDTH+LEN_WIDTH, so the default cannot overflow.

Ports:
- ap_clk  in  1  clock, all state on rising edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a job when in IDLE.
- len  in  LEN_WIDTH  number of products to sum; sampled on accepted start.
- busy  out  1  high whenever the FSM is not IDLE.
- in_valid  in  1  product valid.
- in_data  in  DIN_WIDTH  unsigned product.
- in_ready  out  1  high only in ACC.
- out_valid  out  1  result valid.
- out_data  out  ACC_WIDTH  unsigned sum.
- out_ready  in  1  consumer accepts the result.
- ovf  out  1  overflow flag; meaningful only with the optional feature.

Behaviour:
- Reset (async assert, sync release): state=IDLE, acc=0, cnt=0, busy=0, in_ready=0, out_valid=0, out_data=0, ovf=0.
- FSM states: IDLE, ACC, OUT.
- IDLE:
  - start=1 with len>0: acc<=0, cnt<=len, ovf<=0, go to ACC.
  - start=1 with len=0: acc<=0, go directly to OUT; result is 0.
  - start=0: stay in IDLE.
- ACC:
  - in_ready=1.
  - Each cycle with in_valid&in_ready: acc<=acc+zero_extend(in_data) and cnt<=cnt-1.
  - The beat that takes cnt from 1 to 0 transitions to OUT.
  - in_valid=0 stalls with no change.
- OUT:
  - out_valid=1; out_data=acc, registered and stable while out_valid=1 and out_ready=0.
  - out_valid&out_ready: go to IDLE, clear out_valid.
- Latency:
  - The last product accepted at edge t gives out_valid=1 after edge t (visible in cycle t+1).
  - Earliest new start is accepted the cycle after the out handshake, so min job = len+2 cycles.
- start while busy=1 is ignored; len is not resampled.
- in_data is presented while in_ready=0 is not consumed.
- Arithmetic:
  - Unsigned, modulo 2^ACC_WIDTH without the optional feature.
  - ovf=0 constant without the optional feature.
- Reset asserted mid-job aborts immediately to reset values; no partial result is emitted.
- len = all-ones (1023) must count correctly with no early or late termination.

Optional Feature:
- Macro: DUT_PROD_ACCUM_SAT_EN.
- Defined:
  - The adder carry-out is detected; on carry, acc saturates to 2^ACC_WIDTH-1 and stays there for the rest of the job.
  - ovf is set sticky; it is valid together with out_valid and cleared on the next accepted start.
- Undefined: wrap-around addition, ovf tied 0, no saturation logic synthesized.

Decomposition:
- Shared package dut_prod_accum_pkg holds:
  - State enum (IDLE, ACC, OUT).
  - Default width constants DIN_WIDTH_D=28, LEN_WIDTH_D=10, ACC_WIDTH_D=38.
- One natural sub-module, dut_prod_accum_add: the combinational adder with optional saturation (carry detect + clamp). It is isolated so the macro affects only it.
- FSM and counter stay in the top module.

Test Plan:
- Reset, then start with len=3, products 100, 200, 300 back-to-back, out_ready=1:
  - out_data=600 one cycle after the third accept.
  - busy falls the cycle after the handshake.
- len=4 with in_valid gaps (valid 1,0,0,1,1,0,1), products 2^28-1 each:
  - out_data=4*(2^28-1)=1073741820.
  - in_ready stays 1 during gaps.
- Output backpressure:
  - Hold out_ready=0 for 5 cycles: out_data and out_valid stay stable, in_ready=0, and a start pulse during this time is ignored.
  - Then out_ready=1: FSM returns to IDLE.
- len=0 start: out_valid=1 next cycle with out_data=0, and no input beats are consumed.
- Assert ap_rst_n=0 after 2 of 5 beats: all outputs are 0 immediately.
  - After release, a new job with len=2 (products 7, 8) yields 15, with no residue from the aborted job.
- Build with DUT_PROD_ACCUM_SAT_EN and ACC_WIDTH=29, len=3, products 2^28-1 ×3:
  - out_data=2^29-1, ovf=1.
  - Next job with len=1 (product 5): out_data=5, ovf=0.
